// File: rtl/move_segmenter_if.sv
// Command and segment bus shared by the move source, move_segmenter and the stepper controller.
interface move_segmenter_if #(
  parameter int IN_BITS  = 16,
  parameter int SEG_BITS = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_BITS-1:0]  in_dx;
  logic signed [IN_BITS-1:0]  in_dy;
  logic                       seg_trigger;
  logic signed [SEG_BITS-1:0] seg_dx;
  logic signed [SEG_BITS-1:0] seg_dy;
  logic                       seg_done;
  logic                       busy;

  modport master (
    output in_valid, in_dx, in_dy, seg_done,
    input  in_ready, seg_trigger, seg_dx, seg_dy, busy
  );

  modport slave (
    input  in_valid, in_dx, in_dy, seg_done,
    output in_ready, seg_trigger, seg_dx, seg_dy, busy
  );
endinterface

// File: rtl/move_segmenter.sv
// Splits one signed relative XY move into symmetric-clamped stepper segments, paced by clk_en.
// Optional: define MOVE_SEGMENTER_ZERO_SKIP_EN to drop (0,0) commands without issuing a segment.
module move_segmenter #(
  parameter int IN_BITS  = 16,
  parameter int SEG_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  move_segmenter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic signed [IN_BITS-1:0] SEG_MAX = IN_BITS'((1 << (SEG_BITS - 1)) - 1);

  state_t state_q, state_d;
  logic signed [IN_BITS-1:0]  rem_x_q, rem_x_d;
  logic signed [IN_BITS-1:0]  rem_y_q, rem_y_d;
  logic signed [SEG_BITS-1:0] seg_dx_q, seg_dx_d;
  logic signed [SEG_BITS-1:0] seg_dy_q, seg_dy_d;
  logic signed [IN_BITS-1:0]  clamp_x, clamp_y;
  logic                       in_ready;
  logic                       seg_trigger;

  // Symmetric clamp keeps -2^(SEG_BITS-1) from ever reaching the stepper.
  function automatic logic signed [IN_BITS-1:0] clamp_seg(input logic signed [IN_BITS-1:0] r);
    if (r > SEG_MAX) begin
      return SEG_MAX;
    end else if (r < -SEG_MAX) begin
      return -SEG_MAX;
    end
    return r;
  endfunction

  assign clamp_x = clamp_seg(rem_x_q);
  assign clamp_y = clamp_seg(rem_y_q);

  always_comb begin
    state_d     = state_q;
    rem_x_d     = rem_x_q;
    rem_y_d     = rem_y_q;
    seg_dx_d    = seg_dx_q;
    seg_dy_d    = seg_dy_q;
    seg_trigger = 1'b0;
    in_ready    = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (bus.in_valid) begin
`ifdef MOVE_SEGMENTER_ZERO_SKIP_EN
            if ((bus.in_dx != '0) || (bus.in_dy != '0)) begin
              rem_x_d = bus.in_dx;
              rem_y_d = bus.in_dy;
              state_d = ISSUE;
            end
`else
            rem_x_d = bus.in_dx;
            rem_y_d = bus.in_dy;
            state_d = ISSUE;
`endif
          end
        end
        ISSUE: begin
          seg_trigger = 1'b1;
          seg_dx_d    = clamp_x[SEG_BITS-1:0];
          seg_dy_d    = clamp_y[SEG_BITS-1:0];
          rem_x_d     = rem_x_q - clamp_x;
          rem_y_d     = rem_y_q - clamp_y;
          state_d     = GUARD;
        end
        GUARD: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.seg_done) begin
            if ((rem_x_q == '0) && (rem_y_q == '0)) begin
              state_d = IDLE;
            end else begin
              state_d = ISSUE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_x_q  <= '0;
      rem_y_q  <= '0;
      seg_dx_q <= '0;
      seg_dy_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_x_q  <= rem_x_d;
      rem_y_q  <= rem_y_d;
      seg_dx_q <= seg_dx_d;
      seg_dy_q <= seg_dy_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.seg_trigger = seg_trigger;
  assign bus.seg_dx      = seg_dx_q;
  assign bus.seg_dy      = seg_dy_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_move_segmenter.sv
// Testbench for move_segmenter: vector table, hand-written stall/reset sequences and random moves vs a reference model.
module tb_move_segmenter;

  localparam int IN_BITS  = 16;
  localparam int SEG_BITS = 8;
  localparam int MAXS     = 127;
  localparam int BUDGET   = 8000;
`ifdef MOVE_SEGMENTER_ZERO_SKIP_EN
  localparam int ZERO_SEGS = 0;
`else
  localparam int ZERO_SEGS = 1;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic clk_en = 1'b0;

  move_segmenter_if #(.IN_BITS(IN_BITS), .SEG_BITS(SEG_BITS)) bus ();

  move_segmenter #(.IN_BITS(IN_BITS), .SEG_BITS(SEG_BITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dx;
    int dy;
    int nseg;
    int fx;
    int fy;
    int lx;
    int ly;
  } vec_t;

  int checkCount = 0;
  int passCount  = 0;
  int gotX[$];
  int gotY[$];
  int expX[$];
  int expY[$];
  int earlyTrig;
  bit busySeen;
  bit timedOut;

  task automatic checkOutput(input string name, input int got, input int exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Drives one command and plays the stepper: done drops after each trigger and rises lag ticks later.
  task automatic applyStimulus(input int dx, input int dy, input int lag, input bit randEn);
    int stepBusy;
    bit transferred, finished, trig, xfer, en;
    int v;
    stepBusy = 0;
    transferred = 0;
    finished = 0;
    gotX.delete();
    gotY.delete();
    earlyTrig = 0;
    busySeen = 0;
    timedOut = 0;
    @(negedge clk);
    bus.seg_done = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_dx = IN_BITS'(dx);
    bus.in_dy = IN_BITS'(dy);
    for (int c = 0; c < BUDGET && !finished; c++) begin
      en = randEn ? ($urandom_range(0, 3) != 0) : 1'b1;
      clk_en = en;
      #1;
      trig = bus.seg_trigger;
      xfer = bus.in_valid && bus.in_ready;
      if (trig && (stepBusy != 0 || !bus.seg_done)) earlyTrig++;
      @(posedge clk);
      #1;
      if (bus.busy) busySeen = 1'b1;
      if (trig) begin
        v = bus.seg_dx;
        gotX.push_back(v);
        v = bus.seg_dy;
        gotY.push_back(v);
        stepBusy = lag;
        bus.seg_done = (lag == 0);
      end else if (en && stepBusy > 0) begin
        stepBusy--;
        if (stepBusy == 0) bus.seg_done = 1'b1;
      end
      if (xfer) begin
        bus.in_valid = 1'b0;
        transferred = 1'b1;
      end
      if (transferred && !bus.busy) finished = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!finished) timedOut = 1'b1;
  endtask

  // Segment list from the clamp rule: n = ceil(max|d|/MAX) segments, each axis taking MAX until exhausted.
  function automatic void modelSegments(input int dx, input int dy);
    int ax, ay, n, ny, sx, sy;
    expX.delete();
    expY.delete();
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    n  = (ax + MAXS - 1) / MAXS;
    ny = (ay + MAXS - 1) / MAXS;
    if (ny > n) n = ny;
    if (n == 0) n = ZERO_SEGS;
    for (int k = 0; k < n; k++) begin
      sx = ax - MAXS * k;
      sy = ay - MAXS * k;
      if (sx > MAXS) sx = MAXS;
      if (sx < 0) sx = 0;
      if (sy > MAXS) sy = MAXS;
      if (sy < 0) sy = 0;
      expX.push_back((dx < 0) ? -sx : sx);
      expY.push_back((dy < 0) ? -sy : sy);
    end
  endfunction

  function automatic int pickAxis();
    logic signed [15:0] w;
    case ($urandom_range(0, 7))
      0: return 0;
      1, 2: begin
        w = 16'($urandom);
        return int'(w);
      end
      default: return int'($urandom_range(0, 600)) - 300;
    endcase
  endfunction

  initial begin
    vec_t vecs[$];
    int trigs, mism, n, fx, fy, lx, ly, dx, dy;

    vecs.push_back('{2, 3, 1, 2, 3, 2, 3});
    vecs.push_back('{300, -5, 3, 127, -5, 46, 0});
    vecs.push_back('{-32768, 0, 259, -127, 0, -2, 0});
    vecs.push_back('{127, -127, 1, 127, -127, 127, -127});
    vecs.push_back('{128, 0, 2, 127, 0, 1, 0});
    vecs.push_back('{-128, -255, 3, -127, -127, 0, -1});
    vecs.push_back('{32767, 1, 259, 127, 1, 1, 0});
    vecs.push_back('{0, 0, ZERO_SEGS, 0, 0, 0, 0});

    bus.in_valid = 1'b0;
    bus.in_dx    = '0;
    bus.in_dy    = '0;
    bus.seg_done = 1'b1;
    reset  = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset seg_trigger", int'(bus.seg_trigger), 0);
    checkOutput("reset seg_dx", bus.seg_dx, 0);
    checkOutput("reset seg_dy", bus.seg_dy, 0);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset in_ready en1", int'(bus.in_ready), 1);
    clk_en = 1'b0;
    #1;
    checkOutput("reset in_ready en0", int'(bus.in_ready), 0);
    reset = 1'b1;

    // Stall: done held low in WAIT, then clk_en paused with done already high.
    @(negedge clk);
    clk_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_dx = 16'sd300;
    bus.in_dy = -16'sd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("stall first trigger", int'(bus.seg_trigger), 1);
    @(posedge clk);
    #1;
    bus.seg_done = 1'b0;
    trigs = 0;
    repeat (10) begin
      @(negedge clk);
      trigs += int'(bus.seg_trigger);
    end
    checkOutput("stall no retrigger", trigs, 0);
    checkOutput("stall seg_dx", bus.seg_dx, 127);
    checkOutput("stall seg_dy", bus.seg_dy, -5);
    checkOutput("stall busy", int'(bus.busy), 1);
    clk_en = 1'b0;
    bus.seg_done = 1'b1;
    repeat (20) begin
      @(negedge clk);
      trigs += int'(bus.seg_trigger);
    end
    checkOutput("pause no trigger", trigs, 0);
    checkOutput("pause seg_dx held", bus.seg_dx, 127);
    checkOutput("pause busy held", int'(bus.busy), 1);
    clk_en = 1'b1;
    #1;
    checkOutput("pause state held", int'(bus.seg_trigger), 0);
    @(negedge clk);
    checkOutput("second segment trigger", int'(bus.seg_trigger), 1);

    // Reset lands on the second segment's ISSUE tick.
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset seg_trigger", int'(bus.seg_trigger), 0);
    checkOutput("midreset seg_dx", bus.seg_dx, 0);
    checkOutput("midreset seg_dy", bus.seg_dy, 0);
    checkOutput("midreset busy", int'(bus.busy), 0);
    reset = 1'b1;
    applyStimulus(2, 3, 2, 1'b0);
    checkOutput("post-reset nseg", gotX.size(), 1);
    checkOutput("post-reset seg_dx", (gotX.size() > 0) ? gotX[0] : 9999, 2);
    checkOutput("post-reset seg_dy", (gotY.size() > 0) ? gotY[0] : 9999, 3);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dx, vecs[i].dy, 1 + (i % 3), 1'b1);
      n = gotX.size();
      checkOutput($sformatf("vec%0d nseg", i), n, vecs[i].nseg);
      checkOutput($sformatf("vec%0d timeout", i), int'(timedOut), 0);
      checkOutput($sformatf("vec%0d early trigger", i), earlyTrig, 0);
      checkOutput($sformatf("vec%0d busy seen", i), int'(busySeen), int'(vecs[i].nseg > 0));
      if (vecs[i].nseg > 0) begin
        fx = (n > 0) ? gotX[0] : 9999;
        fy = (n > 0) ? gotY[0] : 9999;
        lx = (n > 0) ? gotX[n-1] : 9999;
        ly = (n > 0) ? gotY[n-1] : 9999;
        checkOutput($sformatf("vec%0d first dx", i), fx, vecs[i].fx);
        checkOutput($sformatf("vec%0d first dy", i), fy, vecs[i].fy);
        checkOutput($sformatf("vec%0d last dx", i), lx, vecs[i].lx);
        checkOutput($sformatf("vec%0d last dy", i), ly, vecs[i].ly);
      end
    end

    for (int r = 0; r < 12; r++) begin
      dx = pickAxis();
      dy = pickAxis();
      applyStimulus(dx, dy, $urandom_range(0, 4), 1'b1);
      modelSegments(dx, dy);
      checkOutput($sformatf("rand%0d (%0d,%0d) nseg", r, dx, dy), gotX.size(), expX.size());
      mism = 0;
      for (int k = 0; k < expX.size() && k < gotX.size(); k++) begin
        if (gotX[k] != expX[k] || gotY[k] != expY[k]) mism++;
      end
      checkOutput($sformatf("rand%0d segment values", r), mism, 0);
      checkOutput($sformatf("rand%0d early trigger", r), earlyTrig, 0);
      checkOutput($sformatf("rand%0d timeout", r), int'(timedOut), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/move_segmenter.md
# move_segmenter

Upstream feeder for the XY stepper controller. Accepts one signed relative move (dx, dy) of up to IN_BITS per axis over a valid/ready handshake. Splits it into segments that fit the stepper controller's signed SEG_BITS step counts, triggers the controller once per segment, and waits for its `done` level between segments. All sequencing advances only on `clk_en` ticks, the same tick that paces the stepper controller.

## Interface
Parameters:
- IN_BITS, 16, width of signed per-axis move command
- SEG_BITS, 8, width of signed per-axis segment; must equal stepper controller COUNT_BITS; IN_BITS > SEG_BITS required

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- clk_en  in  1  step-rate tick; FSM and handshake act only when high
- in_valid  in  1  move command present
- in_ready  out  1  = (state==IDLE) && clk_en; transfer when in_valid && in_ready
- in_dx, in_dy  in  IN_BITS  signed move per axis
- seg_trigger  out  1  one-tick start pulse to stepper controller
- seg_dx, seg_dy  out  SEG_BITS  signed segment steps, registered
- seg_done  in  1  stepper controller `done` level (1 = idle)
- busy  out  1  high in any state other than IDLE

## Operation
- MAX = 2^(SEG_BITS-1)-1 (127 for 8). Segments are clamped symmetrically; -2^(SEG_BITS-1) is never emitted.
- Internal rem_x, rem_y are signed IN_BITS. They are loaded from in_dx/in_dy on transfer.
- Per-axis segment: seg = rem>MAX ? MAX : rem<-MAX ? -MAX : rem. The comparison is signed, so -2^(IN_BITS-1) does not overflow. rem updates to rem-seg.
- Axes are clamped independently. A long move with unequal axes is therefore a dogleg. Straight-line fidelity holds only when both |dx|,|dy| ≤ MAX.
- FSM states and transitions, all evaluated on clk_en ticks:
  - IDLE: on transfer, load rem and go to ISSUE.
  - ISSUE: register seg_dx/seg_dy, update rem, seg_trigger=1, go to GUARD.
  - GUARD: ignore seg_done for one tick, then go to WAIT. This covers the stepper's `done` falling after trigger.
  - WAIT: when seg_done=1 and rem==0, go to IDLE. When seg_done=1 and rem≠0, go to ISSUE. Otherwise stay.
- seg_dx/seg_dy hold stable from ISSUE until the next ISSUE. The stepper controller may sample them at any time.
- On a clk_en=0 cycle, all state, registers and outputs are held. in_ready and seg_trigger are forced low by the clk_en gating.
- Reset values: state IDLE; seg_trigger=0; seg_dx=seg_dy=0; rem=0; busy=0; in_ready follows clk_en.
- Reset mid-operation: the remaining move is discarded and the state returns to IDLE on the next clk edge. The stepper controller shares this reset.
- in_valid during busy: ignored; no transfer until IDLE.

## Timing
- Ticks are clk_en cycles, with T0 the transfer tick:
  - T0: transfer.
  - T1: ISSUE. seg_trigger is high during the clk cycle where state==ISSUE and clk_en=1.
  - T2: GUARD.
  - T3 onward: WAIT.
- Minimum ticks per segment: 3 (ISSUE, GUARD, one WAIT with seg_done=1).
- Turnaround from the last WAIT to IDLE is one tick. The next command can transfer on the following tick.
- seg_trigger is combinational: (state==ISSUE) && clk_en. seg_dx/seg_dy update on that same edge, so they are valid from the next clk cycle.

## Configuration
- MOVE_SEGMENTER_ZERO_SKIP_EN defined: a transferred command with in_dx=in_dy=0 is accepted and dropped. The FSM returns IDLE→IDLE with no seg_trigger, and busy stays 0.
- Undefined: a zero command issues one (0,0) segment, with trigger, GUARD and WAIT as for any other segment.

## Test plan
- Short move (SEG_BITS=8): dx=2, dy=3 -> exactly one trigger with seg=(2,3); busy falls one tick after seg_done=1; rem=0.
- Long move: dx=300, dy=-5 -> three segments (127,-5), (127,0), (46,0); three triggers; each trigger only after seg_done=1 in WAIT.
- Extreme value (IN_BITS=16): dx=-32768, dy=0 -> 258 segments of -127, then one of -2; 259 triggers total; no segment equals -128.
- Stall: hold seg_done=0 for 10 ticks after a trigger -> stays in WAIT with no retrigger and seg_dx/seg_dy stable. clk_en held low for 20 cycles -> no state change and no pulse.
- Zero command: (0,0) with macro -> no trigger and busy stays 0; without macro -> one trigger with seg=(0,0), then IDLE.
- Reset mid-move: assert reset (0) during the second segment of (300,-5) -> next cycle seg_trigger=0, seg=(0,0), busy=0. A new command (2,3) afterwards yields a single segment (2,3).
